// File: rtl/cut_sweep_ctrl.sv
// cut_sweep_ctrl: exhaustive-stimulus sequencer for a small combinational CUT.
// Walks every input vector, waits SETTLE cycles, captures the CUT response,
// streams (vector, response) beats over valid/ready and folds every response
// into a rotate-XOR signature.
// Optional feature: define CUT_SWEEP_GOLDEN_CHECK_EN to add a golden_sig input
// and a registered pass flag comparing the final signature to it.
module cut_sweep_ctrl #(
  parameter int N_IN   = 2,
  parameter int N_OUT  = 18,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic [N_IN-1:0]  cut_x,
  input  logic [N_OUT-1:0] cut_f,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [N_IN-1:0]  resp_vec,
  output logic [N_OUT-1:0] resp_data,
  output logic [N_OUT-1:0] signature,
  output logic             busy,
  output logic             done
`ifdef CUT_SWEEP_GOLDEN_CHECK_EN
  ,
  input  logic [N_OUT-1:0] golden_sig,
  output logic             pass
`endif
);

  if (SETTLE < 1 || SETTLE > 255) begin : g_bad_settle
    $fatal(1, "cut_sweep_ctrl: SETTLE must be in 1..255");
  end

  localparam logic [7:0] SETTLE_M1 = 8'(SETTLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_CAPTURE,
    S_EMIT,
    S_DONE
  } state_t;

  state_t     state;
  logic [7:0] cnt;

  // Sweep sequencer: all outputs are registered and change only here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      cut_x      <= '0;
      resp_valid <= 1'b0;
      resp_vec   <= '0;
      resp_data  <= '0;
      signature  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef CUT_SWEEP_GOLDEN_CHECK_EN
      pass       <= 1'b0;
`endif
    end else if (abort) begin
      // Abandon from any state; signature keeps its partial value.
      state      <= S_IDLE;
      resp_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef CUT_SWEEP_GOLDEN_CHECK_EN
      pass       <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state     <= S_SETTLE;
            cut_x     <= '0;
            cnt       <= SETTLE_M1;
            signature <= '0;
            busy      <= 1'b1;
`ifdef CUT_SWEEP_GOLDEN_CHECK_EN
            pass      <= 1'b0;
`endif
          end
        end
        S_SETTLE: begin
          if (cnt == 8'd0) begin
            state <= S_CAPTURE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        S_CAPTURE: begin
          resp_data  <= cut_f;
          resp_vec   <= cut_x;
          resp_valid <= 1'b1;
          signature  <= {signature[N_OUT-2:0], signature[N_OUT-1]} ^ cut_f;
          state      <= S_EMIT;
        end
        S_EMIT: begin
          if (resp_valid && resp_ready) begin
            resp_valid <= 1'b0;
            if (&cut_x) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              cut_x <= cut_x + N_IN'(1);
              cnt   <= SETTLE_M1;
              state <= S_SETTLE;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
`ifdef CUT_SWEEP_GOLDEN_CHECK_EN
          pass  <= (signature == golden_sig);
`endif
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cut_sweep_ctrl.sv
// Self-checking bench for cut_sweep_ctrl: randomized CUT response tables and
// consumer stalls, checked against a per-vector expectation model.
module tb_cut_sweep_ctrl;

  localparam int N_IN  = 2;
  localparam int N_OUT = 18;
  localparam int NVEC  = 4;

  logic             clk = 1'b0;
  logic             rst_n, start, abort, resp_ready;
  logic [N_IN-1:0]  cut_x, resp_vec;
  logic [N_OUT-1:0] cut_f, resp_data, signature;
  logic             resp_valid, busy, done;
  logic [N_OUT-1:0] f_tab [NVEC];
`ifdef CUT_SWEEP_GOLDEN_CHECK_EN
  logic [N_OUT-1:0] golden_sig;
  logic             pass;
`endif

  // Second instance: SETTLE=4 with a CUT whose output lags its input by 3 cycles.
  logic             start4, abort4, ready4;
  logic [N_IN-1:0]  cut_x4, resp_vec4, d1, d2, d3;
  logic [N_OUT-1:0] cut_f4, resp_data4, signature4;
  logic             resp_valid4, busy4, done4;
`ifdef CUT_SWEEP_GOLDEN_CHECK_EN
  logic [N_OUT-1:0] golden_sig4;
  logic             pass4;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign cut_f  = f_tab[cut_x];
  assign cut_f4 = {16'b0, d3};

  always @(posedge clk) begin
    d1 <= cut_x4;
    d2 <= d1;
    d3 <= d2;
  end

  cut_sweep_ctrl u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .cut_x      (cut_x),
    .cut_f      (cut_f),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_vec   (resp_vec),
    .resp_data  (resp_data),
    .signature  (signature),
    .busy       (busy),
    .done       (done)
`ifdef CUT_SWEEP_GOLDEN_CHECK_EN
    ,
    .golden_sig (golden_sig),
    .pass       (pass)
`endif
  );

  cut_sweep_ctrl #(.SETTLE(4)) u_dut4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start4),
    .abort      (abort4),
    .cut_x      (cut_x4),
    .cut_f      (cut_f4),
    .resp_valid (resp_valid4),
    .resp_ready (ready4),
    .resp_vec   (resp_vec4),
    .resp_data  (resp_data4),
    .signature  (signature4),
    .busy       (busy4),
    .done       (done4)
`ifdef CUT_SWEEP_GOLDEN_CHECK_EN
    ,
    .golden_sig (golden_sig4),
    .pass       (pass4)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected final signature: fold every vector's response in sweep order.
  function automatic logic [N_OUT-1:0] ref_sig();
    logic [N_OUT-1:0] s;
    s = '0;
    for (int v = 0; v < NVEC; v++) s = {s[N_OUT-2:0], s[N_OUT-1]} ^ f_tab[v];
    return s;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_cut_x"}, 32'(cut_x), 0);
    check_eq({tag, "_valid"}, 32'(resp_valid), 0);
    check_eq({tag, "_vec"},   32'(resp_vec), 0);
    check_eq({tag, "_data"},  32'(resp_data), 0);
    check_eq({tag, "_sig"},   32'(signature), 0);
    check_eq({tag, "_busy"},  32'(busy), 0);
    check_eq({tag, "_done"},  32'(done), 0);
`ifdef CUT_SWEEP_GOLDEN_CHECK_EN
    check_eq({tag, "_pass"},  32'(pass), 0);
`endif
  endtask

  // One sweep. stall_mode: 0 ready=1, 1 random ready, 2 five stalls on beat 2.
  // kill_mode: 0 none, 1 abort in EMIT of vector 1, 2 reset in SETTLE of vector 2.
  // Cycle c is the c-th cycle after the edge that samples start.
  task automatic run_sweep(input int stall_mode, input int kill_mode, input bit start_noise);
    int c, beat, stalls, stall_b2;
    bit new_beat;
    logic [N_OUT-1:0] exp_sig;
    exp_sig = ref_sig();
    @(negedge clk);
    start = 1'b1;
    resp_ready = 1'b1;
    @(posedge clk);
    beat = 0; stalls = 0; stall_b2 = 0; new_beat = 1'b1;
    for (c = 1; c <= 200; c++) begin
      @(negedge clk);
      start = start_noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (kill_mode == 2 && c == 7) begin
        check_eq("rst_pre_cut_x", 32'(cut_x), 2);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        check_reset_outputs("midrst");
        return;
      end
      if (done) begin
        start = 1'b0;
        check_eq("done_cycle", c, 13 + stalls);
        check_eq("done_beats", beat, NVEC);
        check_eq("done_busy", 32'(busy), 0);
        check_eq("done_sig", 32'(signature), 32'(exp_sig));
        @(negedge clk);
        check_eq("post_done", 32'(done), 0);
        check_eq("post_busy", 32'(busy), 0);
        check_eq("post_valid", 32'(resp_valid), 0);
        check_eq("post_cut_x", 32'(cut_x), NVEC - 1);
        check_eq("post_sig", 32'(signature), 32'(exp_sig));
        check_eq("post_data", 32'(resp_data), 32'(f_tab[NVEC-1]));
`ifdef CUT_SWEEP_GOLDEN_CHECK_EN
        check_eq("pass", 32'(pass), 32'(exp_sig == golden_sig));
`endif
        return;
      end
      check_eq("busy_high", 32'(busy), 1);
      if (resp_valid) begin
        if (new_beat) check_eq("beat_cycle", c, 3 + 3 * beat + stalls);
        new_beat = 1'b0;
        check_eq("resp_vec", 32'(resp_vec), beat);
        check_eq("resp_data", 32'(resp_data), 32'(f_tab[beat]));
        if (kill_mode == 1 && beat == 1) begin
          abort = 1'b1;
          resp_ready = 1'b0;
          @(negedge clk);
          abort = 1'b0;
          start = 1'b0;
          check_eq("abort_valid", 32'(resp_valid), 0);
          check_eq("abort_busy", 32'(busy), 0);
          check_eq("abort_done", 32'(done), 0);
`ifdef CUT_SWEEP_GOLDEN_CHECK_EN
          check_eq("abort_pass", 32'(pass), 0);
`endif
          repeat (5) begin
            @(negedge clk);
            check_eq("abort_nodone", 32'(done), 0);
            check_eq("abort_idle", 32'(busy), 0);
          end
          return;
        end
        case (stall_mode)
          1:       resp_ready = ($urandom_range(0, 2) != 0);
          2:       resp_ready = !(beat == 2 && stall_b2 < 5);
          default: resp_ready = 1'b1;
        endcase
        if (resp_ready) begin
          beat++;
          new_beat = 1'b1;
        end else begin
          stalls++;
          if (beat == 2) stall_b2++;
        end
      end else begin
        resp_ready = 1'($urandom_range(0, 1));
      end
    end
    check_eq("sweep_timeout", c, 0);
  endtask

  // SETTLE=4 instance with a 3-cycle-lagging CUT: each capture must see its own vector.
  task automatic run_sweep4();
    int c, beat;
    @(negedge clk);
    start4 = 1'b1;
    @(posedge clk);
    beat = 0;
    for (c = 1; c <= 200; c++) begin
      @(negedge clk);
      start4 = 1'b0;
      if (done4) begin
        check_eq("s4_done_cycle", c, 25);
        check_eq("s4_beats", beat, NVEC);
        return;
      end
      if (resp_valid4) begin
        check_eq("s4_beat_cycle", c, 6 + 6 * beat);
        check_eq("s4_vec", 32'(resp_vec4), beat);
        check_eq("s4_data", 32'(resp_data4), beat);
        beat++;
      end
    end
    check_eq("s4_timeout", c, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; resp_ready = 1'b1;
    start4 = 1'b0; abort4 = 1'b0; ready4 = 1'b1;
    for (int i = 0; i < NVEC; i++) f_tab[i] = '0;
`ifdef CUT_SWEEP_GOLDEN_CHECK_EN
    golden_sig = '0;
    golden_sig4 = '0;
`endif
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // start with abort in IDLE: abort wins
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check_eq("sa_busy", 32'(busy), 0);
    repeat (3) begin
      @(negedge clk);
      check_eq("sa_idle", 32'(busy), 0);
    end

    // CUT tied to zero
    run_sweep(0, 0, 0);

    // response = vector, golden match then mismatch
    for (int i = 0; i < NVEC; i++) f_tab[i] = N_OUT'(i);
`ifdef CUT_SWEEP_GOLDEN_CHECK_EN
    golden_sig = 18'h00003;
`endif
    run_sweep(0, 0, 1);
`ifdef CUT_SWEEP_GOLDEN_CHECK_EN
    golden_sig = 18'h00001;
`endif
    run_sweep(0, 0, 0);
    check_eq("ident_sig", 32'(signature), 32'h3);

    // five stall cycles on beat 2: done at cycle 18
    run_sweep(2, 0, 0);

    // abort during EMIT of vector 1, then restart from zero
    run_sweep(0, 1, 0);
    run_sweep(0, 0, 0);

    // reset during SETTLE of vector 2 with start noise, then clean sweep
    run_sweep(0, 2, 1);
    run_sweep(0, 0, 0);

    // random response tables and random consumer stalls
    repeat (8) begin
      for (int i = 0; i < NVEC; i++) f_tab[i] = N_OUT'($urandom);
`ifdef CUT_SWEEP_GOLDEN_CHECK_EN
      golden_sig = ($urandom_range(0, 1) != 0) ? ref_sig() : N_OUT'($urandom);
`endif
      run_sweep(1, 0, 1);
    end

    run_sweep4();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
